// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mul_seq_pkg;

  // Controller states; the encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_addern.sv
// n-bit ripple-carry adder, shared by the multiplier datapath.
module addern #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         ci,
  output logic [n-1:0] sum,
  output logic         co,
  output logic         ovf
);

  logic [n:0] carry;

  assign carry[0] = ci;

  // One full adder per bit, carry rippling from LSB to MSB.
  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_fa
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co  = carry[n];
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf = carry[n] ^ carry[n-1];

endmodule

// File: rtl/mul_seq.sv
// Unsigned sequential shift-add multiplier: one addition per cycle,
// n RUN cycles per operation, exact 2n-bit product.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] product
);

  localparam int CW = $clog2(n + 1);

  state_t         state;
  state_t         state_next;
  logic [n-1:0]   mcand;
  logic [n-1:0]   hi;
  logic [n-1:0]   lo;
  logic [n-1:0]   sum;
  logic           co;
  logic           ovf_unused;
  logic [CW-1:0]  cnt;
  logic           last;
  logic           accept;
  logic [2*n-1:0] shifted;

  // Single shared adder: partial product high half plus multiplicand.
  addern #(.n(n)) u_add (
    .a   (hi),
    .b   (mcand),
    .ci  (1'b0),
    .sum (sum),
    .co  (co),
    .ovf (ovf_unused)
  );

  assign last   = (cnt == CW'(n - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));
  // Next {hi,lo}: add the multiplicand when the current multiplier bit is set,
  // then shift right one place, the adder carry becoming the new MSB.
  assign shifted = lo[0] ? {co, sum, lo[n-1:1]} : {1'b0, hi, lo[n-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs; start is only honoured outside RUN.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iteration and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
      cnt   <= '0;
    end else if (state == RUN) begin
      {hi, lo} <= shifted;
      cnt      <= cnt + CW'(1);
      if (last) product <= shifted;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: timeline reference model plus directed
// and randomized operations.
module tb_mul_seq;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  mul_seq #(.n(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start at edge s means busy in cycles
  // s+1..s+N, done in cycle s+N+1 and product = a*b from cycle s+N+1 on.
  int             cyc = 0;
  int             s_edge = -1;
  logic [2*N-1:0] pend = '0;
  logic [2*N-1:0] m_prod = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_edge = -1;
      m_prod = '0;
      pend   = '0;
    end else begin
      if (s_edge >= 0 && cyc == s_edge + N) m_prod = pend;
      if (start && (s_edge < 0 || cyc >= s_edge + N + 1)) begin
        s_edge = cyc;
        pend   = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      end
      cyc = cyc + 1;
    end
  end

  // Compare DUT status and result against the model every cycle.
  always @(negedge clk) begin
    logic eb, ed;
    eb = (s_edge >= 0) && (cyc >= s_edge + 1) && (cyc <= s_edge + N);
    ed = (s_edge >= 0) && (cyc == s_edge + N + 1);
    chk("cyc_busy", {31'd0, busy}, {31'd0, eb});
    chk("cyc_done", {31'd0, done}, {31'd0, ed});
    chk("cyc_product", {16'd0, product}, {16'd0, m_prod});
  end

  // Caller sits in cycle base+1 (just after edge base). Returns the cycle
  // index of the done pulse, or -1 on timeout. With noise, inputs are
  // scrambled during RUN and start is dropped before DONE.
  task automatic wait_done(input int base, input bit noise, output int k);
    bit found = 1'b0;
    k = -1;
    for (int c = base + 1; c <= base + 40 && !found; c++) begin
      if (noise) begin
        if (c - base <= N) begin
          start = 1'($urandom_range(0, 1));
          a     = N'($urandom);
          b     = N'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        k     = c;
      end else begin
        @(posedge clk); #2;
      end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [2*N-1:0] exp, input bit noise);
    int k;
    @(posedge clk); #2;
    start = 1'b1; a = x; b = y;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(0, noise, k);
    chk({name, "_latency"}, k, N + 1);
    chk({name, "_product"}, {16'd0, product}, {16'd0, exp});
    $display("op %s a=%0d b=%0d product=%0h latency=%0d", name, x, y, product, k);
  endtask

  initial begin
    int k;
    logic [N-1:0] x, y;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;

    // Directed operations with hand-computed results.
    do_op("basic", 8'd3, 8'd5, 16'h000F, 1'b0);
    chk("model_pin_basic", {16'd0, m_prod}, 32'h0000_000F);
    do_op("max", 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    chk("model_pin_max", {16'd0, m_prod}, 32'h0000_FE01);
    do_op("zero", 8'h00, 8'hA5, 16'h0000, 1'b0);
    do_op("shift", 8'h80, 8'h02, 16'h0100, 1'b0);

    // Start held high while busy, with new operands: ignored in RUN, then
    // accepted back-to-back from DONE.
    @(posedge clk); #2;
    start = 1'b1; a = 8'd7; b = 8'd7;
    @(posedge clk); #2;
    a = 8'd9; b = 8'd9;
    wait_done(0, 1'b0, k);
    chk("b2b_first_latency", k, 32'd9);
    chk("b2b_first_product", {16'd0, product}, 32'h0000_0031);
    $display("op b2b_first product=%0h cycle=%0d", product, k);
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(9, 1'b0, k);
    chk("b2b_second_cycle", k, 32'd18);
    chk("b2b_second_product", {16'd0, product}, 32'h0000_0051);
    $display("op b2b_second product=%0h cycle=%0d", product, k);

    // Reset in cycle 4 of RUN: immediate clear, operation abandoned.
    @(posedge clk); #2;
    start = 1'b1; a = 8'd5; b = 8'd6;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_product", {16'd0, product}, 32'd0);
    $display("op midrst busy=%0d product=%0h", busy, product);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done}, 32'd0);
    end
    do_op("after_rst", 8'd2, 8'd3, 16'h0006, 1'b0);

    // Randomized operations with input noise while running.
    for (int i = 0; i < 1000; i++) begin
      x = N'($urandom);
      y = N'($urandom);
      do_op("rand", x, y, {{N{1'b0}}, x} * {{N{1'b0}}, y}, (i % 2) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The module SHALL have parameter n, default 8, giving the operand width in bits (n >= 2).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request a multiply, sampled only in IDLE or DONE.
REQ-005 The module SHALL have port a, input, n bits: unsigned multiplicand, captured when start is accepted.
REQ-006 The module SHALL have port b, input, n bits: unsigned multiplier, captured when start is accepted.
REQ-007 The module SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-009 The module SHALL have port product, output, 2n bits: result of the last completed multiply.

Function
REQ-010 The module SHALL implement an unsigned shift-add multiplier that time-shares one n-bit ripple adder, with ci tied to 0.
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE or DONE with start=1, the FSM SHALL capture mcand=a, set hi=0, set lo=b, clear cnt and go to RUN at that edge.
REQ-013 Each RUN edge where lo[0]=1 SHALL load {hi,lo} <= {co, sum, lo[n-1:1]}, where {co,sum} is the adder output for hi plus mcand.
REQ-014 Each RUN edge where lo[0]=0 SHALL load {hi,lo} <= {1'b0, hi, lo[n-1:1]}.
REQ-015 Each RUN edge SHALL increment cnt, which is clog2(n+1) bits wide.
REQ-016 The RUN edge at which cnt==n-1 SHALL move the FSM to DONE and load product with the final {hi,lo} value.
REQ-017 With start accepted at edge 0, busy SHALL be high in cycles 1..n and done SHALL be high in cycle n+1, giving a fixed latency of n+1 cycles.
REQ-018 DONE with start=0 SHALL return to IDLE at the next edge.
REQ-019 DONE with start=1 SHALL accept the new operation directly (back-to-back), with no IDLE cycle.
REQ-020 start SHALL be ignored in RUN; operands and progress SHALL be unaffected.
REQ-021 product SHALL change only on entry to DONE and SHALL hold its value through IDLE and any subsequent RUN.
REQ-022 The adder overflow output SHALL be left unused.
REQ-023 The full 2n-bit result SHALL be exact for all operands, with no truncation.
REQ-024 busy and done SHALL never be high in the same cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, product=0, hi=0, lo=0, mcand=0 and cnt=0, regardless of clock.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation; no done pulse and no product update SHALL follow.
REQ-027 After reset is released, the first start SHALL be accepted at the first rising edge where rst_n=1.

Structure
REQ-028 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL be defined in a shared package/header, not in module-local literals.
REQ-029 The block SHALL contain exactly one sub-module: the existing n-bit ripple adder (addern), instantiated once with matching n.
REQ-030 The FSM, counter and shift registers SHALL be implemented inline in mul_seq.

Verification
REQ-031 Basic multiply: n=8, a=3, b=5, start pulse at edge 0 -> busy in cycles 1..8, done in cycle 9, product=16'h000F.
REQ-032 Maximum operands: a=8'hFF, b=8'hFF -> product=16'hFE01 at done; confirms carry into hi.
REQ-033 Zero operand: a=8'h00, b=8'hA5 -> product=16'h0000. Follow with a=8'h80, b=8'h02 -> product=16'h0100.
REQ-034 Start while busy: start=1 with a=7, b=7; hold start high for cycles 1..8 with a=9, b=9 -> first done gives 16'h0031. Because start is still high in DONE, a second operation starts back-to-back and its done at cycle 18 gives 16'h0051.
REQ-035 Reset mid-operation: assert rst_n=0 in cycle 4 of RUN -> busy=0, product=0 asynchronously, and no done pulse. After release, a=2, b=3 -> product=16'h0006.
REQ-036 Randomized check: 1000 random 8-bit pairs -> product equals a*b, and the done pulse comes exactly 9 cycles after each accepted start.
